pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipeline control unit for the 6-stage core: PC, IF, ID, EX, MEM, WB.
- Merges per-stage stall requests into the shared stall vector consumed by every pipeline register; stall_o[2]=1 with stall_o[3]=0 makes id_ex insert a bubble.
- Sequences trap entry and mret: drives flush, a one-cycle PC redirect and the CSR trap write strobe.
- Sits beside the pipeline registers; takes exceptions from MEM and branch mispredicts from EX.

Parameters:
- FLUSH_CYCLES, 1, number of cycles flush_o stays high after a trap or mret is accepted (1..7).
- WDOG_LIMIT, 1024, stall-cycle count that trips the watchdog (only used with the optional feature).

Ports:
- clk_i  in  1  clock
- n_rst_i  in  1  asynchronous active-low reset
- stallreq_if_i  in  1  IF stall request
- stallreq_id_i  in  1  ID stall request (load-use)
- stallreq_ex_i  in  1  EX stall request (multi-cycle div)
- stallreq_mem_i  in  1  MEM stall request (bus wait)
- exception_i  in  32  MEM-stage exception flags: [0] ecall, [1] ebreak, [2] illegal, [3] mret, [4] misaligned fetch; other bits ignored
- exception_pc_i  in  32  PC of the excepting instruction
- mtvec_i  in  32  trap vector from CSR
- mepc_i  in  32  return PC from CSR
- br_redirect_i  in  1  EX branch mispredict
- br_target_i  in  32  corrected branch target
- stall_o  out  6  stall vector, [0]=PC .. [5]=WB
- flush_o  out  1  flush IF/ID, ID/EX, EX/MEM
- redirect_o  out  1  PC load strobe
- redirect_pc_o  out  32  PC to load
- trap_we_o  out  1  one-cycle CSR write strobe for mepc/mcause
- trap_cause_o  out  32  mcause value
- trap_epc_o  out  32  mepc value
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (async, n_rst_i=0): state=IDLE, flush count=0. Registered outputs take these values: trap_we_o=0, trap_cause_o=0, trap_epc_o=0, redirect_pc_o=0, busy_o=0. Combinational outputs then evaluate to stall_o=6'b000000, flush_o=0, redirect_o=0.
- Stall merge (combinational), highest active stage wins:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
  - Forced to 0 whenever flush_o=1.
- exc_valid = |exception_i[4:0] while state=IDLE. Trap priority, high to low: misaligned (cause 0), illegal (2), ebreak (3), ecall (11); mret only when no other flag is set.
- FSM states:
  - IDLE -> TRAP when exc_valid and not mret; cycle N.
  - IDLE -> RET when exception_i[3] is the only flag set.
  - TRAP, RET -> FLUSH unconditionally, cycle N+1.
  - FLUSH -> IDLE after the counter reaches FLUSH_CYCLES.
- Cycle N (IDLE with exc_valid): flush_o=1 combinationally; no redirect yet.
- Cycle N+1, TRAP state:
  - redirect_o=1, redirect_pc_o={mtvec_i[31:2],2'b00}.
  - trap_we_o=1, trap_epc_o=exception_pc_i registered at N, trap_cause_o=priority cause.
- Cycle N+1, RET state: redirect_o=1, redirect_pc_o=mepc_i; trap_we_o=0.
- flush_o stays high from N+1 through N+FLUSH_CYCLES. busy_o=1 in every state except IDLE.
- Branch redirect, IDLE only, no exception: redirect_o=br_redirect_i and redirect_pc_o=br_target_i in the same cycle; flush_o=1 for that cycle only. If both occur in one cycle, the exception wins and the branch is dropped.
- exception_i and br_redirect_i are ignored while busy_o=1. Stall requests while busy_o=1 are ignored.
- Asynchronous reset mid-sequence: the FSM returns to IDLE immediately and any pending redirect is lost.

Optional Feature:
- Macro: PIPE_CTRL_STALL_WDOG_EN.
- Defined:
  - A 16-bit counter increments each cycle stall_o!=0 and clears when stall_o==0.
  - When the count reaches WDOG_LIMIT, the controller raises an internal illegal-stall trap (cause 32'h8000_0018, epc=exception_pc_i) through the normal TRAP path, and the counter clears.
  - An extra output wdog_o pulses for one cycle.
- Undefined: no counter, no wdog_o port.

Test Plan:
- Reset: hold n_rst_i=0, drive all requests=1 -> stall_o=0, flush_o=0, redirect_o=0; same after release with all inputs=0.
- Stall priority: stallreq_id_i=1 -> stall_o=6'b000111; add stallreq_mem_i=1 -> 6'b011111; release both -> 0 next evaluation.
- ecall trap: mtvec_i=32'h0000_0103, exception_pc_i=32'h80, exception_i=1 at cycle N -> flush_o=1 at N, N+1. At N+1: redirect_o=1, redirect_pc_o=32'h100, trap_we_o=1, cause=11, epc=32'h80. busy_o=0 at N+2.
- mret: mepc_i=32'h84, exception_i=32'h8 -> at N+1 redirect_pc_o=32'h84, trap_we_o=0.
- Collision: br_redirect_i=1 with exception_i=4 in the same cycle -> branch ignored, cause=2. Second exception during FLUSH (FLUSH_CYCLES=3) -> ignored.
- Watchdog (PIPE_CTRL_STALL_WDOG_EN, WDOG_LIMIT=8): hold stallreq_mem_i=1 for 8 cycles -> wdog_o pulse, trap with cause 32'h8000_0018, stall_o forced 0 during flush.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 6-stage core: stall merge, trap/mret sequencing, branch redirect.
// Optional stall watchdog enabled by defining PIPE_CTRL_STALL_WDOG_EN (adds the wdog_o port).
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_LIMIT   = 1024
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] exception_i,
    input  logic [31:0] exception_pc_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        br_redirect_i,
    input  logic [31:0] br_target_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        trap_we_o,
    output logic [31:0] trap_cause_o,
    output logic [31:0] trap_epc_o,
    output logic        busy_o
`ifdef PIPE_CTRL_STALL_WDOG_EN
    ,
    output logic        wdog_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        RET   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [2:0]  FLUSH_LAST = 3'(FLUSH_CYCLES);
    localparam logic [31:0] WDOG_CAUSE = 32'h8000_0018;

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] trap_cause_q, trap_cause_d;
    logic [31:0] trap_epc_q, trap_epc_d;
    logic        trap_we_q, trap_we_d;
    logic        busy_q;

    logic [4:0]  exc_flags;
    logic        is_idle;
    logic        exc_valid;
    logic        mret_only;
    logic        wdog_fire;
    logic        trap_take;
    logic        ret_take;
    logic        br_take;
    logic [31:0] exc_cause;
    logic [5:0]  stall_merge;
    logic        unused_ok;

    assign exc_flags = exception_i[4:0];
    // Request inputs are gated by reset so nothing leaks out while n_rst_i is low.
    assign is_idle   = (state_q == IDLE) && n_rst_i;
    assign exc_valid = is_idle && (|exc_flags);
    assign mret_only = (exc_flags == 5'b01000);
    assign trap_take = (exc_valid && !mret_only) || wdog_fire;
    assign ret_take  = exc_valid && mret_only;
    assign br_take   = is_idle && !exc_valid && !wdog_fire && br_redirect_i;

    always_comb begin
        exc_cause = 32'd0;
        if (exc_flags[4])      exc_cause = 32'd0;
        else if (exc_flags[2]) exc_cause = 32'd2;
        else if (exc_flags[1]) exc_cause = 32'd3;
        else if (exc_flags[0]) exc_cause = 32'd11;
    end

    always_comb begin
        stall_merge = 6'b000000;
        if (stallreq_mem_i)     stall_merge = 6'b011111;
        else if (stallreq_ex_i) stall_merge = 6'b001111;
        else if (stallreq_id_i) stall_merge = 6'b000111;
        else if (stallreq_if_i) stall_merge = 6'b000011;
    end

    // Busy states coincide with the flush window, so flush covers them all.
    assign flush_o       = n_rst_i && (trap_take || ret_take || br_take || (state_q != IDLE));
    assign stall_o       = (flush_o || !n_rst_i) ? 6'b000000 : stall_merge;
    assign redirect_o    = n_rst_i && ((state_q == TRAP) || (state_q == RET) || br_take);
    assign redirect_pc_o = br_take ? br_target_i : redirect_pc_q;
    assign trap_we_o     = trap_we_q;
    assign trap_cause_o  = trap_cause_q;
    assign trap_epc_o    = trap_epc_q;
    assign busy_o        = busy_q;

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_pc_d = redirect_pc_q;
        trap_cause_d  = trap_cause_q;
        trap_epc_d    = trap_epc_q;
        trap_we_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap_take) begin
                    state_d       = TRAP;
                    flush_cnt_d   = 3'd1;
                    redirect_pc_d = {mtvec_i[31:2], 2'b00};
                    trap_cause_d  = wdog_fire ? WDOG_CAUSE : exc_cause;
                    trap_epc_d    = exception_pc_i;
                    trap_we_d     = 1'b1;
                end else if (ret_take) begin
                    state_d       = RET;
                    flush_cnt_d   = 3'd1;
                    redirect_pc_d = mepc_i;
                end
            end
            TRAP, RET, FLUSH: begin
                if (flush_cnt_q >= FLUSH_LAST) begin
                    state_d     = IDLE;
                    flush_cnt_d = 3'd0;
                end else begin
                    state_d     = FLUSH;
                    flush_cnt_d = flush_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                flush_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q       <= IDLE;
            flush_cnt_q   <= 3'd0;
            redirect_pc_q <= 32'd0;
            trap_cause_q  <= 32'd0;
            trap_epc_q    <= 32'd0;
            trap_we_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_pc_q <= redirect_pc_d;
            trap_cause_q  <= trap_cause_d;
            trap_epc_q    <= trap_epc_d;
            trap_we_q     <= trap_we_d;
            busy_q        <= (state_d != IDLE);
        end
    end

`ifdef PIPE_CTRL_STALL_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT);

    logic [15:0] wdog_cnt_q;

    // A real exception in the same cycle takes precedence; its flush clears the count anyway.
    assign wdog_fire = is_idle && !(|exc_flags) && (wdog_cnt_q == WDOG_LAST);
    assign wdog_o    = wdog_fire;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            wdog_cnt_q <= 16'd0;
        end else if (wdog_fire || (stall_o == 6'b000000)) begin
            wdog_cnt_q <= 16'd0;
        end else begin
            wdog_cnt_q <= wdog_cnt_q + 16'd1;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    assign unused_ok = ^{exception_i[31:5], 16'(WDOG_LIMIT)};

endmodule
